// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_t;

  // Size code presented to memory for every instruction fetch.
  localparam logic [2:0] MEMOP_WORD = 3'b010;

  // Bit positions of the two requesters in request/grant vectors.
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;

  // Encoding of the last_grant history bit.
  localparam logic LAST_FETCH = 1'b0;
  localparam logic LAST_DATA  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter, purely combinational.
// Bit 0 is requester 0, bit 1 is requester 1; i_last_grant holds the index of
// the requester that won most recently, so the other one wins a tie.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_gnt
);

  // Choose at most one winner; a lone requester always wins.
  always_comb begin
    o_gnt = 2'b00;
    if (i_enable) begin
      case (i_req)
        2'b01:   o_gnt = 2'b01;
        2'b10:   o_gnt = 2'b10;
        2'b11:   o_gnt = i_last_grant ? 2'b01 : 2'b10;
        default: o_gnt = 2'b00;
      endcase
    end else begin
      o_gnt = 2'b00;
    end
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port and the load/store port. One transaction is in flight at a time; the
// next one may be granted in the response cycle of the current one.
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_memop,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_memop,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  arb_state_t r_state;
  logic [3:0] r_cnt;
  owner_t     r_owner;
  logic       r_last_grant;
  logic       r_store;

  logic       w_resp;
  logic       w_arb_ok;
  logic [1:0] w_req;
  logic [1:0] w_gnt;

  assign w_resp   = (r_state == BUSY) && (r_cnt == 4'd0);
  assign w_arb_ok = (r_state == IDLE) || w_resp;
  assign w_req    = {d_req, if_req};

  // Arbitration is suppressed while reset is held so every output stays 0
  // even if the CPU is already presenting requests.
  rr_arbiter2 u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .i_enable     (w_arb_ok & reset_n),
    .o_gnt        (w_gnt)
  );

  // Drive grant strobes and the memory command from this cycle's winner.
  always_comb begin
    if_gnt    = w_gnt[REQ_FETCH];
    d_gnt     = w_gnt[REQ_DATA];
    mem_en    = |w_gnt;
    mem_we    = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_memop = 3'b000;
    if (w_gnt[REQ_DATA]) begin
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_memop = d_memop;
    end else if (w_gnt[REQ_FETCH]) begin
      mem_addr  = if_addr;
      mem_memop = MEMOP_WORD;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
    end
  end

  // Route read data to the owner in its single response cycle; stores return 0.
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = {DATA_W{1'b0}};
    d_rvalid  = 1'b0;
    d_rdata   = {DATA_W{1'b0}};
    if (w_resp && (r_owner == OWN_FETCH)) begin
      if_rvalid = 1'b1;
      if_rdata  = mem_rdata;
    end else if (w_resp && (r_owner == OWN_DATA)) begin
      d_rvalid = 1'b1;
      d_rdata  = r_store ? {DATA_W{1'b0}} : mem_rdata;
    end else begin
      d_rvalid = 1'b0;
    end
  end

  // Track the in-flight transaction: owner, remaining latency, tie-break history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_owner      <= OWN_NONE;
      r_last_grant <= LAST_FETCH;
      r_store      <= 1'b0;
    end else if (|w_gnt) begin
      r_state      <= BUSY;
      r_cnt        <= CNT_INIT;
      r_owner      <= w_gnt[REQ_DATA] ? OWN_DATA : OWN_FETCH;
      r_last_grant <= w_gnt[REQ_DATA] ? LAST_DATA : LAST_FETCH;
      r_store      <= w_gnt[REQ_DATA] & d_we;
    end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end else if (r_state == BUSY) begin
      r_state <= IDLE;
      r_owner <= OWN_NONE;
      r_store <= 1'b0;
    end else begin
      r_state <= r_state;
    end
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter. A transaction-level model decides
// which requester is granted each cycle (one transaction per latency window,
// ties go to whoever did not win last) and queues the expected response; a
// separate monitor pops and compares whenever a response is due.
module tb_imem_dmem_arbiter;

  localparam int          LAT  = 2;
  localparam logic [31:0] MASK = 32'hFFFF_0000;

  typedef struct {
    bit          port;   // 0 = fetch, 1 = data
    logic [31:0] data;
    int          due;
  } resp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  memop;
  } dreq_t;

  logic        clock;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [2:0]  d_memop;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_memop;

  // Second instance with single-cycle memory latency.
  logic        rst1_n, if1_req, if1_gnt, if1_rvalid, d1_gnt, d1_rvalid;
  logic [31:0] if1_addr, if1_rdata, d1_rdata;
  logic        mem1_en, mem1_we;
  logic [31:0] mem1_addr, mem1_wdata, mem1_rdata, mem1_last;
  logic [2:0]  mem1_memop;
  logic        zero1;
  logic [31:0] zero32;
  logic [2:0]  zero3;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  resp_t       sb[$];
  logic [31:0] if_src[$];
  dreq_t       d_src[$];
  int          next_arb;
  bit          m_last;      // 0 = fetch won last, 1 = data won last
  bit          saw_if_gnt, saw_d_gnt;
  bit          refill_on;
  int unsigned req_pct;
  logic [31:0] mem_pipe[LAT];

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_memop(d_memop), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_memop(mem_memop), .mem_rdata(mem_rdata)
  );

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_lat1 (
    .clock(clock), .reset_n(rst1_n),
    .if_req(if1_req), .if_addr(if1_addr), .if_gnt(if1_gnt),
    .if_rvalid(if1_rvalid), .if_rdata(if1_rdata),
    .d_req(zero1), .d_we(zero1), .d_addr(zero32), .d_wdata(zero32),
    .d_memop(zero3), .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr),
    .mem_wdata(mem1_wdata), .mem_memop(mem1_memop), .mem_rdata(mem1_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Memory models: read data is address ^ MASK, valid the latency after issue.
  initial for (int i = 0; i < LAT; i++) mem_pipe[i] = 32'h0;
  always @(posedge clock) begin
    mem_pipe[0] <= mem_en ? mem_addr : 32'h0;
    for (int i = 1; i < LAT; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign mem_rdata = mem_pipe[LAT-1] ^ MASK;

  initial mem1_last = 32'h0;
  always @(posedge clock) mem1_last <= mem1_en ? mem1_addr : 32'h0;
  assign mem1_rdata = mem1_last ^ MASK;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic dreq_t mk_d(input logic we, input logic [31:0] a,
                                 input logic [31:0] w, input logic [2:0] m);
    dreq_t r;
    r.we = we; r.addr = a; r.wdata = w; r.memop = m;
    return r;
  endfunction

  task automatic model_reset();
    sb.delete();
    next_arb = 0;
    m_last   = 1'b0;
  endtask

  // Reference model: decide this cycle's winner and compare the command side.
  task automatic model_and_check();
    resp_t r;
    int    win;   // -1 none, 0 fetch, 1 data
    if (!reset_n) begin
      check1("rst_if_gnt", if_gnt, 1'b0);
      check1("rst_d_gnt", d_gnt, 1'b0);
      check1("rst_mem_en", mem_en, 1'b0);
      check1("rst_mem_we", mem_we, 1'b0);
      check32("rst_mem_addr", mem_addr, 32'h0);
      check32("rst_mem_wdata", mem_wdata, 32'h0);
      check32("rst_mem_memop", {29'h0, mem_memop}, 32'h0);
      saw_if_gnt = 1'b0;
      saw_d_gnt  = 1'b0;
      return;
    end
    win = -1;
    if (cyc >= next_arb) begin
      if (if_req && d_req) win = m_last ? 0 : 1;
      else if (if_req)     win = 0;
      else if (d_req)      win = 1;
    end
    check1("if_gnt", if_gnt, win == 0);
    check1("d_gnt", d_gnt, win == 1);
    check1("mem_en", mem_en, win != -1);
    if (win == 0) begin
      check1("fetch_mem_we", mem_we, 1'b0);
      check32("fetch_mem_addr", mem_addr, if_addr);
      check32("fetch_mem_memop", {29'h0, mem_memop}, 32'h2);
      r.port = 1'b0; r.data = if_addr ^ MASK; r.due = cyc + LAT;
      sb.push_back(r);
    end else if (win == 1) begin
      check1("data_mem_we", mem_we, d_we);
      check32("data_mem_addr", mem_addr, d_addr);
      check32("data_mem_wdata", mem_wdata, d_wdata);
      check32("data_mem_memop", {29'h0, mem_memop}, {29'h0, d_memop});
      r.port = 1'b1; r.data = d_we ? 32'h0 : (d_addr ^ MASK); r.due = cyc + LAT;
      sb.push_back(r);
    end
    if (win != -1) begin
      m_last   = (win == 1);
      next_arb = cyc + LAT;
    end
    saw_if_gnt = if_gnt;
    saw_d_gnt  = d_gnt;
  endtask

  // Monitor: compare response outputs against the scoreboard every cycle.
  always @(negedge clock) begin
    logic        exp_if, exp_d;
    logic [31:0] exp_if_data, exp_d_data;
    exp_if = 1'b0; exp_d = 1'b0; exp_if_data = 32'h0; exp_d_data = 32'h0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      if (sb[0].port) begin exp_d = 1'b1; exp_d_data = sb[0].data; end
      else            begin exp_if = 1'b1; exp_if_data = sb[0].data; end
      void'(sb.pop_front());
    end
    check1("if_rvalid", if_rvalid, exp_if);
    check32("if_rdata", if_rdata, exp_if_data);
    check1("d_rvalid", d_rvalid, exp_d);
    check32("d_rdata", d_rdata, exp_d_data);
  end

  // CPU-side drivers: hold each request until granted, then fetch the next.
  task automatic drive_next();
    if (if_req && saw_if_gnt) if_req = 1'b0;
    if (d_req && saw_d_gnt) d_req = 1'b0;
    if (refill_on) begin
      if (if_src.size() < 2) if_src.push_back($urandom & 32'hFFFF_FFFC);
      if (d_src.size() < 2)
        d_src.push_back(mk_d(1'($urandom_range(1, 0)), $urandom & 32'hFFFF_FFFC,
                             $urandom, 3'($urandom_range(7, 0))));
    end
    if (!if_req && if_src.size() > 0 && $urandom_range(99, 0) < req_pct) begin
      if_addr = if_src.pop_front();
      if_req  = 1'b1;
    end
    if (!d_req && d_src.size() > 0 && $urandom_range(99, 0) < req_pct) begin
      dreq_t t;
      t = d_src.pop_front();
      d_we = t.we; d_addr = t.addr; d_wdata = t.wdata; d_memop = t.memop;
      d_req = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clock);
    model_and_check();
    @(posedge clock);
    #1;
    drive_next();
  endtask

  task automatic drain();
    int n;
    n = 0;
    refill_on = 1'b0;
    req_pct   = 100;
    while ((sb.size() != 0 || if_req || d_req || if_src.size() != 0 || d_src.size() != 0)
           && n < 80) begin
      step();
      n++;
    end
    check1("drain_in_time", n < 80, 1'b1);
    step();
    step();
  endtask

  initial begin
    logic [31:0] prev;
    reset_n = 1'b0; rst1_n = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_memop = 3'b000;
    if1_req = 1'b0; if1_addr = 32'h0;
    zero1 = 1'b0; zero32 = 32'h0; zero3 = 3'b000;
    saw_if_gnt = 1'b0; saw_d_gnt = 1'b0;
    model_reset();

    // Directed opening: fetch 0x10 and load 0x20 together, then a store.
    if_src.push_back(32'h0000_0010);
    d_src.push_back(mk_d(1'b0, 32'h0000_0020, 32'h0, 3'b010));
    d_src.push_back(mk_d(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3'b010));
    refill_on = 1'b0;
    req_pct   = 100;
    step();
    step();
    reset_n = 1'b1;
    repeat (8) step();

    // Random traffic with varying request density, including saturation.
    refill_on = 1'b1;
    for (int seg = 0; seg < 6; seg++) begin
      case (seg)
        0: req_pct = 100;
        1: req_pct = 50;
        2: req_pct = 20;
        3: req_pct = 100;
        4: req_pct = 70;
        default: req_pct = 35;
      endcase
      repeat (60) step();
    end
    drain();

    // Lone fetch from idle, then reset one cycle after its grant.
    if_src.push_back(32'h0000_0040);
    step();
    step();
    reset_n = 1'b0;
    model_reset();
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0200; d_memop = 3'b100;
    repeat (4) step();
    reset_n = 1'b1;
    repeat (8) step();
    drain();

    // Single-cycle latency: continuous fetches complete one per cycle.
    rst1_n = 1'b1;
    if1_req = 1'b1;
    if1_addr = 32'h0000_1000;
    prev = 32'h0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      check1("lat1_gnt", if1_gnt, 1'b1);
      check1("lat1_mem_en", mem1_en, 1'b1);
      check1("lat1_rvalid", if1_rvalid, j > 0);
      check32("lat1_rdata", if1_rdata, (j > 0) ? (prev ^ MASK) : 32'h0);
      prev = if1_addr;
      @(posedge clock);
      #1;
      if1_addr = if1_addr + 32'd4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
Shares one single-port, fixed-latency memory between the CPU instruction-fetch port and the CPU load/store port. It is needed when the core moves from split instruction/data memories to a unified memory.
- Arbitrates between the two requesters with round-robin priority.
- Issues one transaction at a time and returns read data to the owner after a fixed latency.
- Sits between the CPU (fetch/load-store) and the unified memory.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MEM_LAT, 2, cycles from issue cycle to read-data cycle; legal range 1..15

Ports:
clock  in  1  system clock, rising-edge active
reset_n  in  1  asynchronous, active-low reset
if_req  in  1  fetch request; held until granted
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch data valid pulse
if_rdata  out  DATA_W  fetch data
d_req  in  1  load/store request; held until granted
d_we  in  1  1 = store
d_addr  in  ADDR_W  load/store address
d_wdata  in  DATA_W  store data
d_memop  in  3  access size/sign code, passed through to memory
d_gnt  out  1  load/store request accepted this cycle
d_rvalid  out  1  load data valid, or store completion pulse
d_rdata  out  DATA_W  load data; 0 for stores
mem_en  out  1  memory access issued this cycle
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_memop  out  3  memory size code; 3'b010 (word) for fetches
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
Reset values:
- Every output is 0. FSM state = IDLE, cnt = 0, owner = none.
- last_grant = FETCH, so data wins the first tie.

States:
- IDLE: no transaction in flight.
- BUSY: transaction in flight; cnt counts down the remaining latency.

Arbitration window (arb_ok):
- arb_ok = (state == IDLE) || (state == BUSY && cnt == 0).
- Decision in the arb_ok cycle is combinational: exactly one of if_gnt/d_gnt goes high, together with mem_en.
- mem_we/mem_addr/mem_wdata/mem_memop are driven from the winner in that same cycle.
- Fetch grants force mem_we = 0 and mem_memop = 3'b010.

Round-robin:
- Only one requester asserting: it wins.
- Both asserting: the one not equal to last_grant wins.
- last_grant updates on every grant.

Grant edge:
- owner <= winner, state <= BUSY, cnt <= MEM_LAT-1.

BUSY with cnt != 0:
- cnt decrements.
- No gnt, no mem_en, no rvalid.

BUSY with cnt == 0 (response cycle):
- owner's rvalid = 1 for exactly this cycle.
- rdata = mem_rdata (combinational pass-through) for reads, 0 for stores.
- The non-owner's rvalid stays 0, and its rdata is held at 0.
- A new grant may issue in the same cycle (back-to-back, one transaction per MEM_LAT cycles).
- No grant in this cycle: state <= IDLE.

Requester contract:
- Requester holds req and all request fields stable until gnt.
- req may drop only after the gnt cycle.
- A requester may re-request in the cycle after gnt; it is not granted until the next arb_ok.

Other rules:
- Stores also occupy the full MEM_LAT and return a d_rvalid pulse; this preserves ordering.
- Reset asserted mid-transaction aborts it: no rvalid afterwards, and all state returns to reset values.
- Request in the IDLE cycle: gnt that same cycle, rvalid exactly MEM_LAT cycles later.

Decomposition:
Shared package mem_arb_pkg:
- typedef arb_state_t {IDLE, BUSY}.
- typedef owner_t {OWN_NONE, OWN_FETCH, OWN_DATA}.
- constant MEMOP_WORD = 3'b010.

Sub-module rr_arbiter2:
- Inputs: req[1:0], last_grant, enable.
- Output: one-hot gnt[1:0].
- Purely combinational; the last_grant register stays in the top module.
- Reusable by later multi-master work.

Test Plan:
1. MEM_LAT=2, mem_rdata model returns addr ^ 32'hFFFF_0000. if_req with if_addr=32'h0000_0040 in IDLE at cycle 0 -> if_gnt=1, mem_en=1, mem_addr=0x40, mem_memop=3'b010 at cycle 0; if_rvalid=1, if_rdata=0xFFFF_0040 at cycle 2 only.
2. Both requesting from reset, fetch 0x10, load 0x20 -> cycle 0 d_gnt (data first); cycle 2 d_rvalid=1, d_rdata=0xFFFF_0020, plus if_gnt same cycle; cycle 4 if_rvalid=1, if_rdata=0xFFFF_0010.
3. Store d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_memop=3'b010 -> mem_we=1, mem_wdata=0xDEADBEEF in the grant cycle; d_rvalid=1 with d_rdata=0 two cycles later; no if_rvalid.
4. Both requesting continuously for 8 transactions -> grants alternate D,F,D,F... every 2 cycles; mem_en never asserts during a cnt!=0 cycle.
5. reset_n low one cycle after a fetch grant (MEM_LAT=2) -> no if_rvalid ever follows; all outputs 0 while reset is held.
6. MEM_LAT=1, if_req held continuously -> grants and if_rvalid both asserted every cycle from cycle 1 onward, giving throughput 1 per cycle.
